// File: rtl/nibble_serial_compare_ctrl.sv
// Serial WIDTH-bit magnitude compare over one shared 4-bit cascadable slice,
// one nibble per clock, LSB nibble first, unsigned or two's-complement.
module nibble_serial_compare_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_ip,
   input  logic             signed_ip,
   input  logic [WIDTH-1:0] a_ip,
   input  logic [WIDTH-1:0] b_ip,
   output logic             busy_op,
   output logic             done_op,
   output logic             a_op_G,
   output logic             a_op_E_b,
   output logic             b_op_G,
   output logic             err_op,
   output logic [3:0]       slice_a_op,
   output logic [3:0]       slice_b_op,
   output logic             slice_a_G_op,
   output logic             slice_b_G_op,
   output logic             slice_E_op,
   input  logic             slice_a_G_ip,
   input  logic             slice_E_ip,
   input  logic             slice_b_G_ip
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int STEP_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NIBBLES - 1);
   localparam logic [2:0]        CASC_EQ   = 3'b001;
   localparam logic [WIDTH-1:0]  MSB_MASK  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [WIDTH-1:0]  opa;
   logic [WIDTH-1:0]  opb;
   logic [WIDTH-1:0]  opa_sh;
   logic [WIDTH-1:0]  opb_sh;
   logic [STEP_W-1:0] step;
   logic [2:0]        casc;
   logic              err_acc;
   logic [2:0]        slice_res;
   logic              bad;
   logic              accept;
   logic              last;

   assign slice_res = {slice_a_G_ip, slice_b_G_ip, slice_E_ip};
   assign bad = !((slice_res == 3'b100) || (slice_res == 3'b010) || (slice_res == 3'b001));
   assign opa_sh = opa >> {step, 2'b00};
   assign opb_sh = opb >> {step, 2'b00};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      busy_op    = 1'b0;
      accept     = 1'b0;
      last       = 1'b0;
      slice_a_op = '0;
      slice_b_op = '0;
      {slice_a_G_op, slice_b_G_op, slice_E_op} = CASC_EQ;
      case (state)
         IDLE: begin
            if (start_ip) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy_op    = 1'b1;
            slice_a_op = opa_sh[3:0];
            slice_b_op = opb_sh[3:0];
            {slice_a_G_op, slice_b_G_op, slice_E_op} = casc;
            if (step == LAST_STEP) begin
               last     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opa      <= '0;
         opb      <= '0;
         step     <= '0;
         casc     <= CASC_EQ;
         err_acc  <= 1'b0;
         done_op  <= 1'b0;
         a_op_G   <= 1'b0;
         a_op_E_b <= 1'b0;
         b_op_G   <= 1'b0;
         err_op   <= 1'b0;
      end else begin
         done_op <= last;
         if (accept) begin
            // Flipping the sign bit maps signed order onto unsigned order.
            opa     <= signed_ip ? (a_ip ^ MSB_MASK) : a_ip;
            opb     <= signed_ip ? (b_ip ^ MSB_MASK) : b_ip;
            step    <= '0;
            casc    <= CASC_EQ;
            err_acc <= 1'b0;
         end else if (state == RUN) begin
            casc    <= slice_res;
            err_acc <= err_acc | bad;
            if (last) begin
               step     <= '0;
               a_op_G   <= slice_a_G_ip;
               b_op_G   <= slice_b_G_ip;
               a_op_E_b <= slice_E_ip;
               err_op   <= err_acc | bad;
            end else begin
               step <= step + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_compare_ctrl.sv
// Scoreboard bench for nibble_serial_compare_ctrl at WIDTH=16 with a
// behavioural model of the 4-bit cascadable comparator slice.
module tb_nibble_serial_compare_ctrl;

   localparam int WIDTH   = 16;
   localparam int NIBBLES = WIDTH / 4;

   // Result encoding {a_op_G, a_op_E_b, b_op_G, err_op}
   localparam logic [3:0] R_EQ    = 4'b0100;
   localparam logic [3:0] R_AG    = 4'b1000;
   localparam logic [3:0] R_BG    = 4'b0010;
   localparam logic [3:0] R_FAULT = 4'b1011;

   typedef struct {
      logic [3:0] res;
      int         due;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_ip;
   logic             signed_ip;
   logic [WIDTH-1:0] a_ip;
   logic [WIDTH-1:0] b_ip;
   logic             busy_op;
   logic             done_op;
   logic             a_op_G;
   logic             a_op_E_b;
   logic             b_op_G;
   logic             err_op;
   logic [3:0]       slice_a_op;
   logic [3:0]       slice_b_op;
   logic             slice_a_G_op;
   logic             slice_b_G_op;
   logic             slice_E_op;
   logic             slice_a_G_ip;
   logic             slice_E_ip;
   logic             slice_b_G_ip;

   logic [2:0] sres;
   logic       force_bad = 1'b0;
   logic       mon_en = 1'b0;
   logic [3:0] held = 4'b0000;
   exp_t       q[$];
   int         cyc = 0;
   int         tests = 0;
   int         fails = 0;

   nibble_serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_ip     (start_ip),
      .signed_ip    (signed_ip),
      .a_ip         (a_ip),
      .b_ip         (b_ip),
      .busy_op      (busy_op),
      .done_op      (done_op),
      .a_op_G       (a_op_G),
      .a_op_E_b     (a_op_E_b),
      .b_op_G       (b_op_G),
      .err_op       (err_op),
      .slice_a_op   (slice_a_op),
      .slice_b_op   (slice_b_op),
      .slice_a_G_op (slice_a_G_op),
      .slice_b_G_op (slice_b_G_op),
      .slice_E_op   (slice_E_op),
      .slice_a_G_ip (slice_a_G_ip),
      .slice_E_ip   (slice_E_ip),
      .slice_b_G_ip (slice_b_G_ip)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   always_comb begin
      if (force_bad && slice_a_op == 4'h5)  sres = 3'b110;
      else if (slice_a_op > slice_b_op)     sres = 3'b100;
      else if (slice_a_op < slice_b_op)     sres = 3'b010;
      else                                  sres = {slice_a_G_op, slice_b_G_op, slice_E_op};
   end
   assign slice_a_G_ip = sres[2];
   assign slice_b_G_ip = sres[1];
   assign slice_E_ip   = sres[0];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: expected busy/done timing and held results come from the queue.
   always @(negedge clk) begin
      logic exp_done;
      logic exp_busy;
      if (mon_en) begin
         while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
         exp_done = (q.size() > 0) && (q[0].due == cyc);
         exp_busy = (q.size() > 0) && (cyc >= q[0].due - NIBBLES) && (cyc < q[0].due);
         chk("busy", 32'(busy_op), 32'(exp_busy));
         chk("done", 32'(done_op), 32'(exp_done));
         if (exp_done) begin
            held = q[0].res;
            void'(q.pop_front());
         end
         chk("result", 32'({a_op_G, a_op_E_b, b_op_G, err_op}), 32'(held));
         if (!exp_busy)
            chk("idle_slice", 32'({slice_a_op, slice_b_op, slice_a_G_op, slice_b_G_op, slice_E_op}),
                32'({4'h0, 4'h0, 3'b001}));
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (!busy_op) return;
      end
      chk("idle_timeout", 32'(1), 32'(0));
   endtask

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic [3:0] res);
      wait_idle();
      a_ip      = a;
      b_ip      = b;
      signed_ip = s;
      start_ip  = 1'b1;
      q.push_back('{res: res, due: cyc + 1 + NIBBLES});
      @(negedge clk); #1;
      start_ip  = 1'b0;
      a_ip      = WIDTH'($urandom);
      b_ip      = WIDTH'($urandom);
      signed_ip = ~s;
   endtask

   initial begin
      rst       = 1'b1;
      start_ip  = 1'b0;
      signed_ip = 1'b0;
      a_ip      = '0;
      b_ip      = '0;
      repeat (3) @(negedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      issue(16'h1234, 16'h1234, 1'b0, R_EQ);
      issue(16'h8000, 16'h7FFF, 1'b0, R_AG);
      issue(16'h8000, 16'h7FFF, 1'b1, R_BG);
      issue(16'h2001, 16'h1FFF, 1'b0, R_AG);
      issue(16'h1235, 16'h1234, 1'b0, R_AG);
      issue(16'hFFFF, 16'hFFFE, 1'b1, R_AG);
      issue(16'h0000, 16'hFFFF, 1'b1, R_AG);

      // start held high: a new compare on every done cycle, ignored while busy
      a_ip      = 16'h0001;
      b_ip      = 16'h0002;
      signed_ip = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_idle();
         start_ip = 1'b1;
         q.push_back('{res: R_BG, due: cyc + 1 + NIBBLES});
         @(negedge clk); #1;
      end
      start_ip = 1'b0;

      // reset in the second RUN cycle abandons the compare
      issue(16'h0003, 16'h0004, 1'b0, R_BG);
      @(negedge clk); #1;
      rst = 1'b1;
      q.delete();
      held = 4'b0000;
      @(negedge clk); #1;
      rst = 1'b0;

      // slice fault on one nibble
      force_bad = 1'b1;
      issue(16'h0050, 16'h0000, 1'b0, R_FAULT);
      wait_idle();
      force_bad = 1'b0;
      issue(16'h0000, 16'h0001, 1'b0, R_BG);

      for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
      #1;
      chk("drain", 32'(q.size()), 32'(0));
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
